jk_reg_bank: RTL and testbench

Parametrised bank of WIDTH JK flip-flops sharing one clock and one asynchronous reset. It extends the single JK flip-flop to a vector register. Each bit takes its own J/K pair, and the block adds a synchronous parallel load, a clock enable, a modulo-MODULUS up-counter mode built from JK toggle equations, and terminal-count and change-detect flags. It is the general-purpose state element for later flip-flop-based counters and control registers.

---
 rtl/jk_reg_bank.sv | 76 +++++++
 tb/tb_jk_reg_bank.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: vector of WIDTH JK flip-flops with synchronous parallel load,
// clock enable, a modulo-MODULUS up-counter mode built from JK toggle
// equations, a terminal-count flag and a registered change-detect flag.
module jk_reg_bank #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int INIT    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             changed
);

  localparam logic [WIDTH-1:0] TC_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  // Characteristic equation of a JK flip-flop, applied bitwise:
  // Q+ = J & ~Q | ~K & Q
  function automatic logic [WIDTH-1:0] jk_update(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] jj,
    input logic [WIDTH-1:0] kk
  );
    return (jj & ~cur) | (~kk & cur);
  endfunction

  logic [WIDTH-1:0] cnt_target;
  logic [WIDTH-1:0] cnt_toggle;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] q_next;

  // Counter next state: any q at or beyond the terminal value restarts at 0,
  // which also recovers out-of-range values left by a load or JK mode.
  // The step is realised as JK flip-flops in toggle form (J=K=T).
  always_comb begin
    cnt_target = (q >= TC_VAL) ? '0 : q + ONE;
    cnt_toggle = q ^ cnt_target;
    cnt_next   = jk_update(q, cnt_toggle, cnt_toggle);
  end

  // Next-state selection with priority load > enable > hold.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = d;
    end else if (en) begin
      if (mode) q_next = cnt_next;
      else      q_next = jk_update(q, j, k);
    end
  end

  // State register and change flag; reset acts immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= INIT_VAL;
      changed <= 1'b0;
    end else begin
      q       <= q_next;
      changed <= (q_next != q);
    end
  end

  assign q_bar = ~q;
  assign tc    = mode && (q == TC_VAL);

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed testbench for jk_reg_bank with WIDTH=4, MODULUS=10, INIT=0.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       mode;
  logic       load;
  logic [3:0] d;
  logic [3:0] j;
  logic [3:0] k;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic       tc;
  logic       changed;

  int n_vec = 0;
  int n_err = 0;

  jk_reg_bank #(
    .WIDTH  (4),
    .MODULUS(10),
    .INIT   (0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .mode   (mode),
    .load   (load),
    .d      (d),
    .j      (j),
    .k      (k),
    .q      (q),
    .q_bar  (q_bar),
    .tc     (tc),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0;
    d = 4'h0; j = 4'h0; k = 4'h0;
    repeat (2) tick();
    check("rst_q", q, 4'h0);
    check("rst_qbar", q_bar, 4'hF);
    check("rst_changed", changed, 1'b0);
    check("rst_tc", tc, 1'b0);

    // Release with en=0: q stays at 0
    reset = 1'b0;
    tick();
    check("rel_q", q, 4'h0);

    // Make q non-zero, then reset between edges
    load = 1'b1; d = 4'h5;
    tick();
    check("ld5_q", q, 4'h5);
    check("ld5_changed", changed, 1'b1);
    load = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_q", q, 4'h0);
    check("async_qbar", q_bar, 4'hF);
    check("async_changed", changed, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rel_q", q, 4'h0);
    check("post_rel_changed", changed, 1'b0);

    // JK truth table, mode 0: bit3 toggle, bit2 set, bit1 clear, bit0 hold
    en = 1'b1; mode = 1'b0; j = 4'b1100; k = 4'b1010;
    tick();
    check("jk1_q", q, 4'b1100);
    check("jk1_changed", changed, 1'b1);
    tick();
    check("jk2_q", q, 4'b0100);
    check("jk2_changed", changed, 1'b1);
    j = 4'b0000; k = 4'b0000;
    tick();
    check("jk_hold_q", q, 4'b0100);
    check("jk_hold_changed", changed, 1'b0);

    // Counter wrap from 0
    load = 1'b1; d = 4'h0;
    tick();
    check("ld0_q", q, 4'h0);
    load = 1'b0; mode = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("cnt_q", q, i[3:0]);
    end
    check("cnt9_tc", tc, 1'b1);
    mode = 1'b0;
    #1 check("tc_mode0", tc, 1'b0);
    mode = 1'b1;
    #1 check("tc_mode1", tc, 1'b1);
    tick();
    check("wrap_q", q, 4'h0);
    check("wrap_tc", tc, 1'b0);
    check("wrap_changed", changed, 1'b1);
    en = 1'b0;
    repeat (3) tick();
    check("en0_q", q, 4'h0);
    check("en0_changed", changed, 1'b0);

    // Load priority and out-of-range recovery
    load = 1'b1; d = 4'hD;
    tick();
    check("ld13_q", q, 4'hD);
    check("ld13_changed", changed, 1'b1);
    check("ld13_tc", tc, 1'b0);
    load = 1'b0; en = 1'b1;
    tick();
    check("oor_q", q, 4'h0);
    mode = 1'b0; j = 4'hF; k = 4'hF; load = 1'b1; d = 4'h6;
    tick();
    check("ld_over_jk_q", q, 4'h6);
    tick();
    check("ld_same_q", q, 4'h6);
    check("ld_same_changed", changed, 1'b0);
    j = 4'h0; k = 4'h0;

    // Count to 7, switch to JK mode
    d = 4'h0;
    tick();
    load = 1'b0; mode = 1'b1;
    repeat (7) tick();
    check("cnt7_q", q, 4'h7);
    mode = 1'b0; j = 4'b0001; k = 4'b0000;
    tick();
    check("sw_hold_q", q, 4'h7);
    check("sw_hold_changed", changed, 1'b0);
    j = 4'b0000; k = 4'b0001;
    tick();
    check("sw_clr_q", q, 4'h6);
    check("sw_clr_changed", changed, 1'b1);

    // Reset mid-cycle while a load is pending
    k = 4'b0000;
    #2 begin reset = 1'b1; load = 1'b1; d = 4'hF; end
    #1;
    check("rst_mid_q", q, 4'h0);
    tick();
    check("rst_ld_q", q, 4'h0);
    check("rst_ld_changed", changed, 1'b0);
    reset = 1'b0; load = 1'b0; mode = 1'b1; en = 1'b1;
    tick();
    check("after_rst_q", q, 4'h1);
    check("after_rst_qbar", q_bar, 4'hE);
    check("after_rst_changed", changed, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
